// File: rtl/mmcm_seq_pkg.sv
// Shared types and constants for the MMCM lock sequencer.
package mmcm_seq_pkg;

  localparam int LOCK_LOSS_W = 8;

  typedef enum logic [2:0] {
    ST_RST_MMCM  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } mmcm_seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mmcm_lock_sequencer_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the CLK domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // Shift chain; cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// Power-up/re-lock controller: pulses MMCM reset, qualifies LOCKED, then releases the core reset.
module mmcm_lock_sequencer
  import mmcm_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   MMCM_LOCKED,
  input  logic                   RELOCK_REQ,
  output logic                   MMCM_RST,
  output logic                   CORE_RESET,
  output logic                   READY,
  output logic                   FAIL,
  output logic [RW-1:0]          RETRY_CNT,
  output logic [LOCK_LOSS_W-1:0] LOCK_LOSS_CNT
);

  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  mmcm_seq_state_t        state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [LOCK_LOSS_W-1:0] loss_q, loss_d;
  logic                   lk_s;
  logic                   mmcm_rst_q, core_reset_q, ready_q, fail_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (MMCM_LOCKED),
    .q_o   (lk_s)
  );

  // Next-state, shared counter and retry/loss counter updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_RST_MMCM: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == RW'(MAX_RETRIES)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RST_MMCM;
            retry_d = retry_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STABLE: begin
        // A dropout while qualifying is a glitch: re-wait without charging a retry.
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_d = ST_RST_MMCM;
          cnt_d   = '0;
          retry_d = '0;
          if (loss_q != {LOCK_LOSS_W{1'b1}}) begin
            loss_d = loss_q + LOCK_LOSS_W'(1);
          end else begin
            loss_d = loss_q;
          end
        end else if (RELOCK_REQ) begin
          state_d = ST_RST_MMCM;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: begin
        if (RELOCK_REQ) begin
          state_d = ST_RST_MMCM;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_RST_MMCM;
        cnt_d   = '0;
      end
    endcase
  end

  // State/counter registers and Moore outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_RST_MMCM;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      mmcm_rst_q   <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      mmcm_rst_q   <= (state_d == ST_RST_MMCM);
      core_reset_q <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  assign MMCM_RST      = mmcm_rst_q;
  assign CORE_RESET    = core_reset_q;
  assign READY         = ready_q;
  assign FAIL          = fail_q;
  assign RETRY_CNT     = retry_q;
  assign LOCK_LOSS_CNT = loss_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Directed self-checking bench for mmcm_lock_sequencer (RST=4, TIMEOUT=20, STABLE=8, RETRIES=2, SYNC=2).
module tb_mmcm_lock_sequencer;

  logic       clk;
  logic       reset;
  logic       mmcm_locked;
  logic       relock_req;
  logic       mmcm_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  mmcm_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK           (clk),
    .RESET         (reset),
    .MMCM_LOCKED   (mmcm_locked),
    .RELOCK_REQ    (relock_req),
    .MMCM_RST      (mmcm_rst),
    .CORE_RESET    (core_reset),
    .READY         (ready),
    .FAIL          (fail),
    .RETRY_CNT     (retry_cnt),
    .LOCK_LOSS_CNT (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rst, input logic e_core,
                          input logic e_ready, input logic e_fail);
    chk_bit({tag, ".mmcm_rst"}, mmcm_rst, e_rst);
    chk_bit({tag, ".core_reset"}, core_reset, e_core);
    chk_bit({tag, ".ready"}, ready, e_ready);
    chk_bit({tag, ".fail"}, fail, e_fail);
  endtask

  // Advance n cycles, requiring MMCM_RST to stay low on every one of them.
  task automatic run_rst0(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      chk_bit(tag, mmcm_rst, 1'b0);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk_bit(tag, ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    mmcm_locked = 1'b0;
    relock_req  = 1'b0;
    tick(3);
    chk_outs("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("reset.retry", 8'(retry_cnt), 8'd0);
    chk_val("reset.loss", lock_loss_cnt, 8'd0);

    // 1 Nominal bring-up
    reset = 1'b0;
    tick(3);
    chk_bit("nom.rst_hi", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("nom.rst_lo", mmcm_rst, 1'b0);
    mmcm_locked = 1'b1;
    tick(10);
    chk_outs("nom.before_ready", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_outs("nom.ready", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_val("nom.retry", 8'(retry_cnt), 8'd0);

    // 4 Lock loss in RUN
    mmcm_locked = 1'b0;
    tick(2);
    chk_bit("loss.still_run", ready, 1'b1);
    tick(1);
    chk_outs("loss.reseq", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("loss.cnt1", lock_loss_cnt, 8'd1);
    mmcm_locked = 1'b1;
    tick(3);
    chk_bit("loss.rst_hi", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("loss.rst_lo", mmcm_rst, 1'b0);
    tick(8);
    chk_bit("loss.not_ready", ready, 1'b0);
    tick(1);
    chk_bit("loss.ready", ready, 1'b1);

    // 5 RELOCK_REQ in RUN
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_outs("relock_run", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("relock_run.loss", lock_loss_cnt, 8'd1);
    tick(3);
    chk_bit("relock_run.rst_hi", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("relock_run.rst_lo", mmcm_rst, 1'b0);
    tick(1);

    // RELOCK_REQ while in STABLE is ignored
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_outs("relock_stable", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(6);
    chk_bit("relock_stable.not_ready", ready, 1'b0);
    tick(1);
    chk_bit("relock_stable.ready", ready, 1'b1);

    // Lock loss and RELOCK_REQ sampled in the same cycle
    mmcm_locked = 1'b0;
    tick(2);
    chk_bit("both.still_run", ready, 1'b1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_outs("both.reseq", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("both.loss_once", lock_loss_cnt, 8'd2);

    // 3 Glitch during STABLE
    tick(4);
    chk_bit("glitch.wait_lock", mmcm_rst, 1'b0);
    mmcm_locked = 1'b1;
    run_rst0("glitch.no_pulse", 5);
    mmcm_locked = 1'b0;
    run_rst0("glitch.no_pulse", 1);
    mmcm_locked = 1'b1;
    run_rst0("glitch.no_pulse", 2);
    chk_outs("glitch.back", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("glitch.retry", 8'(retry_cnt), 8'd0);
    run_rst0("glitch.no_pulse", 8);
    chk_bit("glitch.not_ready", ready, 1'b0);
    tick(1);
    chk_bit("glitch.ready", ready, 1'b1);

    // 2 Timeout / retry to FAIL
    mmcm_locked = 1'b0;
    tick(3);
    chk_bit("to.rst0_hi", mmcm_rst, 1'b1);
    chk_val("to.loss3", lock_loss_cnt, 8'd3);
    chk_val("to.retry0", 8'(retry_cnt), 8'd0);
    tick(3);
    chk_bit("to.rst0_end", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("to.wait1", mmcm_rst, 1'b0);
    tick(19);
    chk_bit("to.wait1_end", mmcm_rst, 1'b0);
    chk_val("to.retry0b", 8'(retry_cnt), 8'd0);
    tick(1);
    chk_bit("to.rst1", mmcm_rst, 1'b1);
    chk_val("to.retry1", 8'(retry_cnt), 8'd1);
    tick(3);
    chk_bit("to.rst1_end", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("to.wait2", mmcm_rst, 1'b0);
    tick(19);
    chk_bit("to.wait2_end", mmcm_rst, 1'b0);
    tick(1);
    chk_bit("to.rst2", mmcm_rst, 1'b1);
    chk_val("to.retry2", 8'(retry_cnt), 8'd2);
    tick(3);
    chk_bit("to.rst2_end", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("to.wait3", mmcm_rst, 1'b0);
    tick(19);
    chk_bit("to.not_fail", fail, 1'b0);
    tick(1);
    chk_outs("to.fail", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_val("to.retry_fail", 8'(retry_cnt), 8'd2);

    // FAIL is sticky against LOCKED, cleared by RELOCK_REQ
    mmcm_locked = 1'b1;
    tick(5);
    chk_outs("fail.sticky", 1'b0, 1'b1, 1'b0, 1'b1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_outs("fail.relock", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("fail.relock_retry", 8'(retry_cnt), 8'd0);
    tick(3);
    chk_bit("fail.rst_hi", mmcm_rst, 1'b1);
    tick(1);
    chk_bit("fail.rst_lo", mmcm_rst, 1'b0);
    tick(8);
    chk_bit("fail.not_ready", ready, 1'b0);
    tick(1);
    chk_bit("fail.ready", ready, 1'b1);

    // 6 Lock-loss counter saturation
    for (int i = 1; i <= 260; i++) begin
      mmcm_locked = 1'b0;
      tick(3);
      chk_bit("sat.core_reset", core_reset, 1'b1);
      if (i == 251) chk_val("sat.cnt254", lock_loss_cnt, 8'd254);
      if (i == 252) chk_val("sat.cnt255", lock_loss_cnt, 8'd255);
      mmcm_locked = 1'b1;
      wait_ready("sat.relock", 30);
    end
    chk_val("sat.final", lock_loss_cnt, 8'd255);

    // RESET while in STABLE
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(5);
    chk_outs("rst_stable.pre", 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1);
    chk_outs("rst_stable.post", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("rst_stable.retry", 8'(retry_cnt), 8'd0);
    chk_val("rst_stable.loss", lock_loss_cnt, 8'd0);
    reset = 1'b0;
    tick(12);
    chk_bit("rst_stable.not_ready", ready, 1'b0);
    tick(1);
    chk_bit("rst_stable.ready", ready, 1'b1);
    chk_val("rst_stable.loss_after", lock_loss_cnt, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
